// File: rtl/bus_test_sequencer.sv
// Command-memory driven bus test sequencer.
// Runs WRITE / READ_CHECK programs and tallies per-test pass/fail counts.
module bus_test_sequencer #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int NUM_TESTS = 4,
    parameter int CMD_DEPTH = 64,
    parameter int TIMEOUT   = 255,
    localparam int CW   = $clog2(CMD_DEPTH),
    localparam int TW   = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
    localparam int CMDW = 2 + ADDR_W + DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    input  logic              cmd_we,
    input  logic [CW-1:0]     cmd_addr,
    input  logic [CMDW-1:0]   cmd_wdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic [TW-1:0]     cur_test,
    input  logic [TW-1:0]     res_sel,
    output logic [15:0]       res_pass,
    output logic [15:0]       res_fail
);

    localparam int TOW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_END  = 2'd0;
    localparam logic [1:0] OP_WR   = 2'd1;
    localparam logic [1:0] OP_RD   = 2'd2;
    localparam logic [1:0] OP_HALT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CMDW-1:0]   mem [CMD_DEPTH];
    logic [CMDW-1:0]   cmd;
    logic [CW-1:0]     pc;
    logic [TOW-1:0]    tcnt;
    logic [15:0]       pass_cnt [NUM_TESTS];
    logic [15:0]       fail_cnt [NUM_TESTS];

    logic [1:0]        op;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic              is_bus_op;
    logic              bus_phase;
    logic              last_pc;
    logic              last_test;
    logic              acc_ack;
    logic              acc_to;

    assign op        = cmd[CMDW-1 -: 2];
    assign c_addr    = cmd[DATA_W +: ADDR_W];
    assign c_data    = cmd[DATA_W-1:0];
    assign is_bus_op = (op == OP_WR) || (op == OP_RD);
    assign bus_phase = (state == S_EXEC) || (state == S_ACCESS);
    assign last_pc   = (pc == CW'(CMD_DEPTH - 1));
    assign last_test = (cur_test == TW'(NUM_TESTS - 1));
    assign acc_ack   = (state == S_ACCESS) && bus_ack;
    assign acc_to    = (state == S_ACCESS) && !bus_ack
                    && (tcnt == TOW'(TIMEOUT - 1));

    // Strobes decode straight from the state register so reset kills them at once.
    assign busy      = (state == S_FETCH) || (state == S_EXEC)
                    || (state == S_ACCESS);
    assign done      = (state == S_DONE);
    assign bus_we    = (state == S_ACCESS) && (op == OP_WR);
    assign bus_re    = (state == S_ACCESS) && (op == OP_RD);
    assign bus_addr  = (bus_phase && is_bus_op) ? c_addr : '0;
    assign bus_wdata = (bus_phase && op == OP_WR) ? c_data : '0;

    always_ff @(posedge clk) begin
        if (cmd_we && !busy) begin
            mem[cmd_addr] <= cmd_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_WR, OP_RD: state_nxt = S_ACCESS;
                    OP_END: begin
                        if (last_test || last_pc) state_nxt = S_DONE;
                        else                      state_nxt = S_FETCH;
                    end
                    default: state_nxt = S_DONE;
                endcase
            end
            S_ACCESS: begin
                if (acc_ack || acc_to) begin
                    state_nxt = last_pc ? S_DONE : S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd      <= '0;
            pc       <= '0;
            tcnt     <= '0;
            cur_test <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_TESTS; i++) begin
                pass_cnt[i] <= '0;
                fail_cnt[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pc       <= '0;
                        cur_test <= '0;
                        overflow <= 1'b0;
                        for (int i = 0; i < NUM_TESTS; i++) begin
                            pass_cnt[i] <= '0;
                            fail_cnt[i] <= '0;
                        end
                    end
                end
                S_FETCH: begin
                    cmd  <= mem[pc];
                    tcnt <= '0;
                end
                S_EXEC: begin
                    if (op == OP_END) begin
                        if (last_test) overflow <= 1'b1;
                        else           cur_test <= cur_test + TW'(1);
                        if (state_nxt == S_FETCH) pc <= pc + CW'(1);
                    end
                end
                S_ACCESS: begin
                    tcnt <= tcnt + TOW'(1);
                    if (acc_ack || acc_to) begin
                        if (state_nxt == S_FETCH) pc <= pc + CW'(1);
                        if (acc_to || (op == OP_RD && bus_rdata != c_data)) begin
                            if (fail_cnt[cur_test] != 16'hFFFF)
                                fail_cnt[cur_test] <= fail_cnt[cur_test] + 16'd1;
                        end else if (op == OP_RD) begin
                            if (pass_cnt[cur_test] != 16'hFFFF)
                                pass_cnt[cur_test] <= pass_cnt[cur_test] + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        res_pass = '0;
        res_fail = '0;
        if (int'(res_sel) < NUM_TESTS) begin
            res_pass = pass_cnt[res_sel];
            res_fail = fail_cnt[res_sel];
        end
    end

endmodule
